// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex seven-segment scanner with frame-synchronous loading and anode guard cycle.
// Define SEG_LZB_EN to enable leading-zero blanking of the shadowed value.
module seg_scan_driver #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 131072,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);
    localparam int W  = 6 * DIGITS;
    localparam logic AL = ACTIVE_LOW != 0;
    localparam logic [6:0] SEG_OFF = {7{AL}};
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{AL}};

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d, cur_q, cur_d;
    logic              guard_q, guard_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              dp_q, dp_d;
    logic              fd_q, fd_d;
    logic [W-1:0]      pd_q, pd_d, sh_q, sh_d;
    logic              pv_q, pv_d;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0] sh_blank, sh_dp;
    logic              tick, boundary, dark, lzb;
    logic [3:0]        nib;
`ifdef SEG_LZB_EN
    logic              z;
`endif

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;
            4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    assign {sh_val, sh_blank, sh_dp} = sh_q;

    // Suppression of digit idx: it and every more-significant digit are zero with no dp set
    always_comb begin
        lzb = 1'b0;
`ifdef SEG_LZB_EN
        z = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z = z && sh_val[4*i +: 4] == 4'd0 && !sh_dp[i];
            if (IW'(i) == idx_q) lzb = z;
        end
`endif
    end

    always_comb begin
        tick     = cnt_q == CW'(SCAN_DIV - 1);
        boundary = tick && idx_q == '0;
        nib      = sh_val[4*idx_q +: 4];
        dark     = sh_blank[idx_q] | lzb;
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        idx_d    = tick ? (idx_q == '0 ? IW'(DIGITS - 1) : idx_q - IW'(1)) : idx_q;
        cur_d    = tick ? idx_q : cur_q;
        guard_d  = tick;
        seg_d    = tick ? (dark ? SEG_OFF : enc(nib) ^ {7{~AL}}) : seg_q;
        dp_d     = tick ? AL ^ (!dark && sh_dp[idx_q]) : dp_q;
        an_d     = tick ? AN_OFF : guard_q ? AN_OFF ^ (DIGITS'(1) << cur_q) : an_q;
        fd_d     = boundary;
        pd_d     = load ? {value, blank, dp_in} : pd_q;
        pv_d     = boundary ? 1'b0 : load ? 1'b1 : pv_q;
        sh_d     = !boundary ? sh_q : load ? {value, blank, dp_in} : pv_q ? pd_q : sh_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q   <= '0;
            idx_q   <= IW'(DIGITS - 1);
            cur_q   <= IW'(DIGITS - 1);
            guard_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
            dp_q    <= AL;
            fd_q    <= 1'b0;
            pd_q    <= '0;
            sh_q    <= '0;
            pv_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cur_q   <= cur_d;
            guard_q <= guard_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
            pd_q    <= pd_d;
            sh_q    <= sh_d;
            pv_q    <= pv_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;
endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed seven-segment driver: scans DIGITS common-anode digits from an internal scan divider clocked by the single system clock (no derived clock domain).
- Displays a hex value with per-digit blanking and decimal points.
- Adds tear-free frame-synchronous loading, an anode-off guard cycle against ghosting, and configurable output polarity.
- Sits between the CPU/debug logic and the board display pins.

Parameters:
- DIGITS, 4, number of digits; ≥2.
- SCAN_DIV, 131072, clk cycles per digit slot; ≥2.
- ACTIVE_LOW, 1, 1 = seg/an/dp are driven low-active; 0 = all three outputs inverted.

Ports:
- clk  in  1  system clock (50 MHz on board).
- clr  in  1  reset; synchronous, active-high.
- load  in  1  one-cycle strobe; captures value/blank/dp_in.
- value  in  4*DIGITS  hex nibbles; nibble i shows on digit i; digit 0 is rightmost, an[0].
- blank  in  DIGITS  1 = force digit i dark.
- dp_in  in  DIGITS  1 = light decimal point of digit i.
- seg  out  7  {g,f,e,d,c,b,a}.
- an  out  DIGITS  anode enables.
- dp  out  1  decimal point.
- frame_done  out  1  one-cycle pulse after last digit of a frame is emitted.

Behaviour:
- Interface: one clock, clk; reset clr is synchronous and active-high. All outputs are registered.
- Reset values, shown for ACTIVE_LOW=1:
  - seg=7'b1111111, an all ones, dp=1, frame_done=0.
  - Divider cnt=0, idx=DIGITS-1.
  - Shadow value/blank/dp=0, pending_valid=0.
  - Reset mid-frame aborts the scan immediately and discards pending data.
- Divider: cnt increments every clk and wraps SCAN_DIV-1→0. tick is true while cnt==SCAN_DIV-1. The first tick occurs in cycle SCAN_DIV-1 after reset release.
- On the tick edge:
  - seg ← enc(shadow nibble idx).
  - dp ← shadow dp[idx].
  - an ← all off.
  - cur ← idx.
  - idx ← (idx==0) ? DIGITS-1 : idx-1. Scan order is leftmost→rightmost.
- Guard: on the edge following a tick, an ← one-hot(cur). Each digit is therefore lit SCAN_DIV-1 cycles per slot, with the anode off for 1 cycle.
- Encoding, active-low codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blanked digit: seg all off and dp off. The anode is still scanned.
- Loading:
  - load captures inputs into the pending register and sets pending_valid.
  - A second load before the frame boundary overwrites the pending data (last wins).
- Frame boundary = tick with idx==0:
  - Outputs for digit 0 use the old shadow.
  - On the same edge, shadow ← pending if pending_valid, and pending_valid ← 0.
  - frame_done=1 the following cycle only.
  - A displayed frame therefore never mixes old and new data.
- load coincident with the boundary tick: the loaded inputs go straight to shadow, and pending_valid ends at 0.
- ACTIVE_LOW=0: seg, an and dp are the bitwise inverse of the above, including reset values.

Optional Feature:
- Macro SEG_LZB_EN enables leading-zero blanking, computed from the shadow registers.
- With it, digit i (i≥1) is blanked when its nibble and every more-significant nibble are 0, and no dp at digit i or above is set.
  - A set dp stops suppression at that digit (e.g. "0.5" keeps its 0).
  - Digit 0 is never suppressed. Explicit blank still applies.
- Without it, all non-blank digits are shown, including leading zeros.

Test Plan (DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1):
- Scan order and guard:
  - Stimulus: release clr, load value=16'h1234, dp_in=0.
  - Required: first tick at cycle 3; an sequence 1111(guard)→0111 with seg=1111001, then 1011/0100100, 1101/0110000, 1110/0011001.
  - Required: each anode low for 3 cycles, all-high for exactly 1 cycle between digits, frame_done pulse after digit 0.
- Tear-free load:
  - Stimulus: load 16'hABCD mid-frame while showing 16'h1234.
  - Required: remaining digits of the current frame still show 3,4; next frame shows A,b,C,d.
- Last load wins / boundary load:
  - Stimulus: two loads (16'h1111 then 16'h2222) in one frame.
  - Required: next frame shows 2222.
  - Stimulus: load asserted exactly on the idx==0 tick.
  - Required: the new value is displayed from the next frame and pending stays empty.
- Blank and dp:
  - Stimulus: blank=4'b0100, dp_in=4'b0001, value=16'h8888.
  - Required: digit 2 seg=1111111 and dp=1; digit 0 dp=0; the others show 0000000.
- Reset mid-operation:
  - Stimulus: assert clr for 1 cycle during the guard cycle with pending load held.
  - Required: next cycle seg=1111111, an=1111, frame_done=0; after release the display shows 0000 (old pending discarded).
- SEG_LZB_EN:
  - value=16'h0050 → digits 3,2 dark; digits 1,0 show 5,0.
  - value=16'h0000 → only digit 0 shows 0.
  - value=16'h0050 with dp_in=4'b0100 → digit 2 shows "0.".
